// File: rtl/ring_msg_framer_pkg.sv
// ring_msg_framer_pkg: header field layout and FSM encoding
// shared by the ring message framer and anything that builds headers.
package ring_msg_framer_pkg;

    localparam int DEST_HI = 31;
    localparam int DEST_LO = 28;
    localparam int TYPE_HI = 27;
    localparam int TYPE_LO = 24;
    localparam int LEN_HI  = 5;
    localparam int LEN_LO  = 0;
    localparam int LEN_W   = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PAY  = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    // Payload length carried in a header word.
    function automatic logic [LEN_W-1:0] hdr_len(input logic [31:0] hdr);
        return hdr[LEN_HI:LEN_LO];
    endfunction

endpackage

// File: rtl/ring_msg_framer.sv
// ring_msg_framer: drains a FWFT queue into sop/eop-framed ring
// messages; oversize messages are swallowed whole and counted.
module ring_msg_framer
    import ring_msg_framer_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MAX_LEN = 63
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] q_dout,
    input  logic             q_empty,
    output logic             q_rd_en,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             out_sop,
    output logic             out_eop,
    input  logic             out_ready,
    output logic             drop_pulse,
    output logic [7:0]       drop_count,
    output logic             busy
);

    localparam logic [LEN_W-1:0] MAX_LEN_W = LEN_W'(MAX_LEN);

    state_t             r_state;
    logic [LEN_W-1:0]   r_remaining;
    logic [WIDTH-1:0]   r_out_data;
    logic               r_out_valid;
    logic               r_out_sop;
    logic               r_out_eop;
    logic               r_drop_pulse;
    logic [7:0]         r_drop_count;

    logic               w_can_load;
    logic               w_rd_en;
    logic [LEN_W-1:0]   w_len;
    logic               w_last;

    assign w_can_load = ~r_out_valid | out_ready;
    assign w_len      = hdr_len(q_dout[31:0]);
    assign w_last     = (r_remaining == LEN_W'(1));

    // Pop decision: DROP ignores the output slot; reset forces no pop.
    always_comb begin
        w_rd_en = 1'b0;
        unique case (r_state)
            ST_IDLE, ST_PAY: w_rd_en = ~q_empty & w_can_load;
            ST_DROP:         w_rd_en = ~q_empty;
            default:         w_rd_en = 1'b0;
        endcase
        if (!rst_n) begin
            w_rd_en = 1'b0;
        end
    end

    // Framing FSM with the one-entry output register folded in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_remaining  <= '0;
            r_out_data   <= '0;
            r_out_valid  <= 1'b0;
            r_out_sop    <= 1'b0;
            r_out_eop    <= 1'b0;
            r_drop_pulse <= 1'b0;
            r_drop_count <= '0;
        end else begin
            r_drop_pulse <= 1'b0;
            if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
            unique case (r_state)
                ST_IDLE: begin
                    if (w_rd_en) begin
                        if (w_len == '0) begin
                            r_out_data  <= q_dout;
                            r_out_valid <= 1'b1;
                            r_out_sop   <= 1'b1;
                            r_out_eop   <= 1'b1;
                        end else if (w_len <= MAX_LEN_W) begin
                            r_out_data  <= q_dout;
                            r_out_valid <= 1'b1;
                            r_out_sop   <= 1'b1;
                            r_out_eop   <= 1'b0;
                            r_remaining <= w_len;
                            r_state     <= ST_PAY;
                        end else begin
                            r_drop_pulse <= 1'b1;
                            if (r_drop_count != 8'hFF) begin
                                r_drop_count <= r_drop_count + 8'd1;
                            end
                            r_remaining <= w_len;
                            r_state     <= ST_DROP;
                        end
                    end
                end
                ST_PAY: begin
                    if (w_rd_en) begin
                        r_out_data  <= q_dout;
                        r_out_valid <= 1'b1;
                        r_out_sop   <= 1'b0;
                        r_out_eop   <= w_last;
                        r_remaining <= r_remaining - LEN_W'(1);
                        if (w_last) begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                ST_DROP: begin
                    if (w_rd_en) begin
                        r_remaining <= r_remaining - LEN_W'(1);
                        if (w_last) begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign q_rd_en    = w_rd_en;
    assign out_data   = r_out_data;
    assign out_valid  = r_out_valid;
    assign out_sop    = r_out_sop;
    assign out_eop    = r_out_eop;
    assign drop_pulse = r_drop_pulse;
    assign drop_count = r_drop_count;
    assign busy       = (r_state != ST_IDLE) | r_out_valid;

endmodule

// File: tb/tb_ring_msg_framer.sv
// tb_ring_msg_framer: table-driven cycle vectors against a queue
// model, plus hand sequences for drop saturation and mid-message reset.
module tb_ring_msg_framer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] q_dout;
    logic        q_empty;
    logic        q_rd_en;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_sop;
    logic        out_eop;
    logic        out_ready;
    logic        drop_pulse;
    logic [7:0]  drop_count;
    logic        busy;

    ring_msg_framer #(.WIDTH(32), .MAX_LEN(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .q_dout     (q_dout),
        .q_empty    (q_empty),
        .q_rd_en    (q_rd_en),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_sop    (out_sop),
        .out_eop    (out_eop),
        .out_ready  (out_ready),
        .drop_pulse (drop_pulse),
        .drop_count (drop_count),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          push;
        logic [31:0] w;
        bit          rdy;
        bit          rd;
        bit          vld;
        logic [31:0] d;
        bit          sop;
        bit          eop;
        bit          bsy;
        bit          dp;
    } vec_t;

    logic [31:0] fifo[$];
    vec_t        tbl[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          n_pops = 0;
    bit          pop_now;

    function automatic vec_t V(bit push, logic [31:0] w, bit rdy, bit rd,
                               bit vld, logic [31:0] d, bit sop, bit eop,
                               bit bsy, bit dp);
        vec_t v;
        v.push = push; v.w = w; v.rdy = rdy; v.rd = rd; v.vld = vld;
        v.d = d; v.sop = sop; v.eop = eop; v.bsy = bsy; v.dp = dp;
        return v;
    endfunction

    task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic drive_q();
        q_empty = (fifo.size() == 0);
        q_dout  = q_empty ? 32'h0 : fifo[0];
    endtask

    // Called at the negedge: record the pop, then model the queue pop
    // just after the rising edge.
    task automatic finish_cycle();
        chk("rd_en_while_empty", {31'b0, q_rd_en & q_empty}, 32'h0);
        pop_now = q_rd_en;
        @(posedge clk);
        #1;
        if (pop_now) begin
            fifo.delete(0);
            n_pops++;
        end
        drive_q();
    endtask

    task automatic tick();
        @(negedge clk);
        finish_cycle();
    endtask

    task automatic run_tbl(string name);
        for (int i = 0; i < tbl.size(); i++) begin
            string t;
            if (tbl[i].push) fifo.push_back(tbl[i].w);
            out_ready = tbl[i].rdy;
            drive_q();
            @(negedge clk);
            t = $sformatf("%s[%0d]", name, i);
            chk({t, ".rd_en"}, {31'b0, q_rd_en}, {31'b0, tbl[i].rd});
            chk({t, ".valid"}, {31'b0, out_valid}, {31'b0, tbl[i].vld});
            chk({t, ".busy"}, {31'b0, busy}, {31'b0, tbl[i].bsy});
            chk({t, ".drop_pulse"}, {31'b0, drop_pulse}, {31'b0, tbl[i].dp});
            if (tbl[i].vld) begin
                chk({t, ".data"}, out_data, tbl[i].d);
                chk({t, ".sop"}, {31'b0, out_sop}, {31'b0, tbl[i].sop});
                chk({t, ".eop"}, {31'b0, out_eop}, {31'b0, tbl[i].eop});
            end
            finish_cycle();
        end
        tbl.delete();
    endtask

    localparam logic [31:0] H3 = 32'h1200_0003;
    localparam logic [31:0] WA = 32'hAAAA_0001;
    localparam logic [31:0] WB = 32'hBBBB_0002;
    localparam logic [31:0] WC = 32'hCCCC_0003;

    initial begin
        int p0;
        int guard;
        int bad_vld;
        rst_n = 1'b0;
        out_ready = 1'b0;
        drive_q();
        repeat (2) @(posedge clk);
        #1;
        chk("rst.valid", {31'b0, out_valid}, 32'h0);
        chk("rst.data", out_data, 32'h0);
        chk("rst.count", {24'b0, drop_count}, 32'h0);
        chk("rst.busy", {31'b0, busy}, 32'h0);
        rst_n = 1'b1;

        // 3-word message, full throughput
        fifo = '{H3, WA, WB, WC};
        p0 = n_pops;
        tbl.push_back(V(0, 0, 1, 1, 0, 0,  0, 0, 0, 0));
        tbl.push_back(V(0, 0, 1, 1, 1, H3, 1, 0, 1, 0));
        tbl.push_back(V(0, 0, 1, 1, 1, WA, 0, 0, 1, 0));
        tbl.push_back(V(0, 0, 1, 1, 1, WB, 0, 0, 1, 0));
        tbl.push_back(V(0, 0, 1, 0, 1, WC, 0, 1, 1, 0));
        tbl.push_back(V(0, 0, 1, 0, 0, 0,  0, 0, 0, 0));
        run_tbl("msg3");
        chk("msg3.pops", n_pops - p0, 4);

        // zero-length message
        fifo = '{32'h5100_0000};
        tbl.push_back(V(0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(V(0, 0, 1, 0, 1, 32'h5100_0000, 1, 1, 1, 0));
        tbl.push_back(V(0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        run_tbl("len0");

        // backpressure stalls on A
        fifo = '{H3, WA, WB, WC};
        p0 = n_pops;
        tbl.push_back(V(0, 0, 1, 1, 0, 0,  0, 0, 0, 0));
        tbl.push_back(V(0, 0, 1, 1, 1, H3, 1, 0, 1, 0));
        tbl.push_back(V(0, 0, 0, 0, 1, WA, 0, 0, 1, 0));
        tbl.push_back(V(0, 0, 0, 0, 1, WA, 0, 0, 1, 0));
        tbl.push_back(V(0, 0, 0, 0, 1, WA, 0, 0, 1, 0));
        tbl.push_back(V(0, 0, 1, 1, 1, WA, 0, 0, 1, 0));
        tbl.push_back(V(0, 0, 1, 1, 1, WB, 0, 0, 1, 0));
        tbl.push_back(V(0, 0, 1, 0, 1, WC, 0, 1, 1, 0));
        tbl.push_back(V(0, 0, 1, 0, 0, 0,  0, 0, 0, 0));
        run_tbl("bp");
        chk("bp.pops", n_pops - p0, 4);

        // underrun: words trickle in with 3-cycle gaps
        tbl.push_back(V(1, 32'h3400_0002, 1, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(V(0, 0, 1, 0, 1, 32'h3400_0002, 1, 0, 1, 0));
        tbl.push_back(V(0, 0, 1, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(V(0, 0, 1, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(V(1, WA, 1, 1, 0, 0, 0, 0, 1, 0));
        tbl.push_back(V(0, 0, 1, 0, 1, WA, 0, 0, 1, 0));
        tbl.push_back(V(0, 0, 1, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(V(0, 0, 1, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(V(1, WB, 1, 1, 0, 0, 0, 0, 1, 0));
        tbl.push_back(V(0, 0, 1, 0, 1, WB, 0, 1, 1, 0));
        tbl.push_back(V(0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        run_tbl("gap");

        // oversize len=10 (MAX_LEN=4) then a len=1 message
        fifo = '{32'h0000_000A};
        for (int i = 0; i < 10; i++) fifo.push_back(32'hD000_0000 + i);
        fifo.push_back(32'h2000_0001);
        fifo.push_back(32'hDDDD_0000);
        p0 = n_pops;
        tbl.push_back(V(0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(V(0, 0, 1, 1, 0, 0, 0, 0, 1, 1));
        for (int i = 2; i <= 10; i++)
            tbl.push_back(V(0, 0, 1, 1, 0, 0, 0, 0, 1, 0));
        tbl.push_back(V(0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(V(0, 0, 1, 1, 1, 32'h2000_0001, 1, 0, 1, 0));
        tbl.push_back(V(0, 0, 1, 0, 1, 32'hDDDD_0000, 0, 1, 1, 0));
        tbl.push_back(V(0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        run_tbl("drop");
        chk("drop.pops", n_pops - p0, 13);
        chk("drop.count", {24'b0, drop_count}, 32'd1);

        // 255 more oversize messages: count saturates at 255
        for (int m = 0; m < 255; m++) begin
            fifo.push_back(32'h0F00_0005);
            for (int i = 0; i < 5; i++) fifo.push_back(32'hE000_0000 + i);
        end
        out_ready = 1'b1;
        drive_q();
        guard = 0;
        bad_vld = 0;
        while (fifo.size() != 0 && guard < 2000) begin
            if (out_valid) bad_vld++;
            tick();
            guard++;
        end
        tick();
        chk("sat.timeout", {31'b0, guard >= 2000}, 32'h0);
        chk("sat.no_output", bad_vld, 0);
        chk("sat.count", {24'b0, drop_count}, 32'd255);

        // reset while in PAY
        fifo = '{H3, WA, WB, WC};
        tbl.push_back(V(0, 0, 1, 1, 0, 0,  0, 0, 0, 0));
        tbl.push_back(V(0, 0, 1, 1, 1, H3, 1, 0, 1, 0));
        run_tbl("prerst");
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst.valid", {31'b0, out_valid}, 32'h0);
        chk("mrst.sop", {31'b0, out_sop}, 32'h0);
        chk("mrst.eop", {31'b0, out_eop}, 32'h0);
        chk("mrst.data", out_data, 32'h0);
        chk("mrst.count", {24'b0, drop_count}, 32'h0);
        chk("mrst.busy", {31'b0, busy}, 32'h0);
        fifo = '{32'h7300_0001, 32'hEEEE_0005};
        drive_q();
        #1;
        chk("mrst.rd_en", {31'b0, q_rd_en}, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tbl.push_back(V(0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(V(0, 0, 1, 1, 1, 32'h7300_0001, 1, 0, 1, 0));
        tbl.push_back(V(0, 0, 1, 0, 1, 32'hEEEE_0005, 0, 1, 1, 0));
        tbl.push_back(V(0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        run_tbl("postrst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
